// File: rtl/booth_r4_seq_mult_if.sv
// Handshake and data bundle for booth_r4_seq_mult.
// The master drives the operands and start; the slave (the multiplier)
// returns ready/busy/done and the product.
interface booth_r4_seq_mult_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   ready;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, signed_mode, a, b,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, signed_mode, a, b,
        output ready, busy, done, product
    );
endinterface

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier: one Booth digit (-2..+2) per clock.
// Operands are extended to WIDTH+2 bits (sign- or zero-extended by
// signed_mode) so one datapath serves both unsigned and signed products.
// Optional macro BOOTH_R4_EARLY_TERM_EN: stop as soon as the remaining
// multiplier bits can only produce zero digits.
module booth_r4_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    booth_r4_seq_mult_if.slave   bus
);
    localparam int DIGITS = WIDTH / 2 + 1;
    localparam int EXT    = WIDTH + 2;
    localparam int ACC    = 2 * WIDTH + 2;
    localparam int CNT_W  = $clog2(DIGITS + 1);

    generate
        if ((WIDTH < 4) || (WIDTH % 2 != 0)) begin : g_bad_width
            $error("booth_r4_seq_mult: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 state_q, state_d;
    // Multiplicand pre-shifted by 4^k, so each digit only picks +-1x/+-2x.
    logic [ACC-1:0]         mcand_q, mcand_d;
    // Extended multiplier with the implicit 0 at bit 0; shifted right by
    // two per digit so the current triplet is always bits [2:0].
    logic [EXT:0]           mplier_q, mplier_d;
    logic [ACC-1:0]         acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     product_q, product_d;
    logic                   done_q, done_d;

    logic [ACC-1:0]         pp;
    logic                   last_digit;
    logic                   rest_zero;
    logic                   unused_acc_hi;

    // The two guard bits of the accumulator never reach the product.
    assign unused_acc_hi = ^acc_q[ACC-1:2*WIDTH];

    // Booth digit selection from the current triplet.
    always_comb begin
        pp = '0;
        unique case (mplier_q[2:0])
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = mcand_q << 1;
            3'b100:         pp = -(mcand_q << 1);
            3'b101, 3'b110: pp = -mcand_q;
            default:        pp = '0;
        endcase
    end

    assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));

`ifdef BOOTH_R4_EARLY_TERM_EN
    // Upper bits all equal means every later triplet is 000 or 111.
    assign rest_zero = (&mplier_q[EXT:2]) | ~(|mplier_q[EXT:2]);
`else
    assign rest_zero = 1'b0;
`endif

    // Next-state and datapath updates for IDLE/RUN/DONE.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mcand_d  = bus.signed_mode ?
                               {{(ACC-WIDTH){bus.a[WIDTH-1]}}, bus.a} :
                               {{(ACC-WIDTH){1'b0}}, bus.a};
                    mplier_d = bus.signed_mode ?
                               {{2{bus.b[WIDTH-1]}}, bus.b, 1'b0} :
                               {2'b00, bus.b, 1'b0};
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_q + pp;
                mcand_d  = mcand_q << 2;
                mplier_d = {{2{mplier_q[EXT]}}, mplier_q[EXT:2]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_digit || rest_zero) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                product_d = acc_q[2*WIDTH-1:0];
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign bus.ready   = (state_q == S_IDLE);
    assign bus.busy    = (state_q == S_RUN);
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Bench for booth_r4_seq_mult (WIDTH=8): directed cases with literal
// expectations plus random operations checked against an arithmetic model.
module tb_booth_r4_seq_mult;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_at_edge = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] held = '0;

    booth_r4_seq_mult_if #(.WIDTH(8)) bif ();

    booth_r4_seq_mult #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_at_edge = rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact product of the operands in the selected mode, low 16 bits.
    function automatic logic [15:0] model_prod(input logic [7:0] ma, input logic [7:0] mb, input logic msm);
        int sa, sb, p;
        sa = msm ? int'($signed(ma)) : int'(ma);
        sb = msm ? int'($signed(mb)) : int'(mb);
        p  = sa * sb;
        return p[15:0];
    endfunction

    // Edges from accepted start to the edge after which done is high.
    function automatic int exp_lat(input logic [7:0] mb, input logic msm);
`ifdef BOOTH_R4_EARLY_TERM_EN
        logic [9:0] e;
        int n;
        bit eq;
        e = msm ? {{2{mb[7]}}, mb} : {2'b00, mb};
        n = 5;
        for (int k = 0; k < 5; k++) begin
            eq = 1'b1;
            for (int i = 2 * k + 1; i <= 9; i++) begin
                if (e[i] != e[2 * k + 1]) eq = 1'b0;
            end
            if (eq) begin
                n = k + 1;
                break;
            end
        end
        return n + 1;
`else
        return 6 + 0 * int'({mb, msm});
`endif
    endfunction

    // Cycle-by-cycle monitor: reset state, product hold and done results.
    always @(negedge clk) begin
        if (rst_at_edge) begin
            exp_q.delete();
            held = '0;
            check("rst_ready", bif.ready, 1);
            check("rst_busy", bif.busy, 0);
            check("rst_done", bif.done, 0);
            check("rst_product", bif.product, 0);
        end else begin
            check("ready_busy_excl", bif.ready & bif.busy, 0);
            if (bif.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    held = exp_q.pop_front();
                    check("mon_product", bif.product, held);
                end
            end else begin
                check("product_held", bif.product, held);
            end
        end
    end

    task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input logic osm,
                         input int inj, output logic [15:0] prod, output int lat, output int bcnt);
        int w;
        w = 0;
        @(negedge clk);
        while (!bif.ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bif.ready) check("ready_wait", 0, 1);
        bif.a = oa;
        bif.b = ob;
        bif.signed_mode = osm;
        bif.start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model_prod(oa, ob, osm));
        #1 bif.start = 1'b0;
        lat  = -1;
        bcnt = 0;
        prod = '0;
        for (int e = 0; e < 100; e++) begin
            @(negedge clk);
            if (bif.busy) bcnt++;
            if (bif.done) begin
                lat  = e;
                prod = bif.product;
                break;
            end
            if (e == inj) begin
                bif.a = 8'd5;
                bif.b = 8'd5;
                bif.signed_mode = 1'b0;
                bif.start = 1'b1;
            end else begin
                bif.a = 8'($urandom);
                bif.b = 8'($urandom);
                bif.signed_mode = 1'($urandom);
            end
            @(posedge clk);
            #1 bif.start = 1'b0;
        end
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    initial begin
        logic [15:0] p;
        int lat, bc;
        logic [7:0] ra, rb;
        logic rsm;

        bif.start = 1'b0;
        bif.signed_mode = 1'b0;
        bif.a = '0;
        bif.b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        do_op(8'd255, 8'd255, 1'b0, -1, p, lat, bc);
        $display("op 255*255 unsigned -> 0x%0h lat %0d busy %0d", p, lat, bc);
        check("prod_255x255", p, 16'hFE01);
        check("lat_255x255", lat, 6);
        check("busy_255x255", bc, 5);

        do_op(8'h80, 8'h80, 1'b1, -1, p, lat, bc);
        $display("op -128*-128 signed -> 0x%0h", p);
        check("prod_s_m128sq", p, 16'h4000);

        do_op(8'hFF, 8'd127, 1'b1, -1, p, lat, bc);
        $display("op -1*127 signed -> 0x%0h", p);
        check("prod_s_m1x127", p, 16'hFF81);

        do_op(8'h80, 8'h80, 1'b0, -1, p, lat, bc);
        $display("op 0x80*0x80 unsigned -> 0x%0h", p);
        check("prod_u_80x80", p, 16'h4000);

        do_op(8'h80, 8'h01, 1'b0, -1, p, lat, bc);
        $display("op 0x80*0x01 unsigned -> 0x%0h", p);
        check("prod_u_80x01", p, 16'h0080);

        do_op(8'h80, 8'h01, 1'b1, -1, p, lat, bc);
        $display("op 0x80*0x01 signed -> 0x%0h", p);
        check("prod_s_80x01", p, 16'hFF80);

        do_op(8'd7, 8'd9, 1'b0, 2, p, lat, bc);
        $display("op 7*9 with start pulse while busy -> %0d", p);
        check("prod_ignored_start", p, 16'd63);

        do_op(8'd200, 8'd3, 1'b0, -1, p, lat, bc);
        $display("op 200*3 unsigned -> %0d lat %0d", p, lat);
        check("prod_200x3", p, 16'd600);
`ifdef BOOTH_R4_EARLY_TERM_EN
        check("lat_200x3", lat, 3);
`else
        check("lat_200x3", lat, 6);
`endif
        check("busy_200x3", bc, lat - 1);

        // Back-to-back: the second start arrives in the cycle after done.
        do_op(8'd17, 8'd19, 1'b0, -1, p, lat, bc);
        check("prod_17x19", p, 16'd323);
        do_op(8'd3, 8'd4, 1'b0, -1, p, lat, bc);
        $display("op back-to-back 3*4 -> %0d", p);
        check("prod_b2b_3x4", p, 16'd12);

        // Reset in the middle of an operation.
        @(negedge clk);
        bif.a = 8'd9;
        bif.b = 8'd9;
        bif.signed_mode = 1'b0;
        bif.start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model_prod(8'd9, 8'd9, 1'b0));
        #1 bif.start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        $display("op 9*9 aborted by reset -> product 0x%0h ready %0d", bif.product, bif.ready);
        check("midrst_ready", bif.ready, 1);
        check("midrst_product", bif.product, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("midrst_no_done", bif.done, 0);
        end

        for (int t = 0; t < 40; t++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rsm = 1'($urandom);
            if (t < 4) rb = (t % 2 == 0) ? 8'h00 : 8'hFF;
            do_op(ra, rb, rsm, -1, p, lat, bc);
            $display("op rand %0d: 0x%0h*0x%0h sm=%0d -> 0x%0h lat %0d", t, ra, rb, rsm, p, lat);
            check("rand_prod", p, model_prod(ra, rb, rsm));
            check("rand_lat", lat, exp_lat(rb, rsm));
            check("rand_busy", bc, exp_lat(rb, rsm) - 1);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
